path_delay_stage: RTL and testbench

- Cycle-based hardware model of one specify-block module path (input -> output) with per-transition delays and PATHPULSE-style pulse filtering.
- Sits directly downstream of the specify/specparam stage. It consumes the elaborated six-value delay set and the reject/error limits, and applies them to a 4-state signal.
- Time unit is one clk cycle.
- 4-state encoding: 2'b00 = 0, 2'b01 = 1, 2'b10 = z, 2'b11 = x.

---
 rtl/path_delay_pkg.sv | 68 ++++++
 rtl/path_delay_if.sv | 23 ++
 rtl/path_delay_sel.sv | 24 ++
 rtl/path_delay_stage.sv | 130 +++++++++++++
 tb/tb_path_delay_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/path_delay_pkg.sv
// Shared values, enums and the per-transition delay lookup for one module path.
package path_delay_pkg;

  localparam int unsigned MAX_DW    = 32;
  localparam int unsigned NUM_TRANS = 6;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  typedef enum logic [2:0] {
    T01 = 3'd0,
    T10 = 3'd1,
    T0Z = 3'd2,
    TZ1 = 3'd3,
    T1Z = 3'd4,
    TZ0 = 3'd5
  } trans_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_REJ  = 2'd1,
    CLS_ERR  = 2'd2,
    CLS_PASS = 2'd3
  } pulse_cls_e;

  typedef logic [MAX_DW-1:0]       dly_t;
  typedef dly_t [NUM_TRANS-1:0]    dly_set_t;

  function automatic dly_t dly_min(input dly_t a, input dly_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic dly_t dly_max(input dly_t a, input dly_t b);
    return (a > b) ? a : b;
  endfunction

  // Delay for src->dst; to-x takes the minimum, from-x the maximum of the six.
  function automatic dly_t trans_delay(input logic [1:0] src, input logic [1:0] dst,
                                       input dly_set_t cfg);
    dly_t lo;
    dly_t hi;
    dly_t d;
    lo = dly_min(dly_min(dly_min(cfg[0], cfg[1]), dly_min(cfg[2], cfg[3])),
                 dly_min(cfg[4], cfg[5]));
    hi = dly_max(dly_max(dly_max(cfg[0], cfg[1]), dly_max(cfg[2], cfg[3])),
                 dly_max(cfg[4], cfg[5]));
    d  = '0;
    if (dst == VX) begin
      d = lo;
    end else if (src == VX) begin
      d = hi;
    end else begin
      case ({src, dst})
        {V0, V1}: d = cfg[T01];
        {V1, V0}: d = cfg[T10];
        {V0, VZ}: d = cfg[T0Z];
        {VZ, V1}: d = cfg[TZ1];
        {V1, VZ}: d = cfg[T1Z];
        {VZ, V0}: d = cfg[TZ0];
        default:  d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/path_delay_if.sv
// Path input, delay configuration and delayed output bundle.
interface path_delay_if #(
  parameter int unsigned DW = 8
);
  logic [1:0]      in_val;
  logic [6*DW-1:0] dly_cfg;
  logic [DW-1:0]   rej_lim;
  logic [DW-1:0]   err_lim;
  logic [1:0]      out_val;
  logic            busy;
  logic            pulse_rej;
  logic            pulse_err;

  modport master (
    output in_val, dly_cfg, rej_lim, err_lim,
    input  out_val, busy, pulse_rej, pulse_err
  );

  modport slave (
    input  in_val, dly_cfg, rej_lim, err_lim,
    output out_val, busy, pulse_rej, pulse_err
  );
endinterface

// File: rtl/path_delay_sel.sv
// Combinational delay selection for a single src->dst transition.
module path_delay_sel
  import path_delay_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [1:0]      src,
  input  logic [1:0]      dst,
  input  logic [6*DW-1:0] cfg,
  output logic [DW-1:0]   dly_c
);

  dly_set_t cfg_ext;

  // Widen each packed delay field and look up the transition delay.
  always_comb begin
    cfg_ext = '0;
    for (int i = 0; i < 6; i++) begin
      cfg_ext[i] = MAX_DW'(cfg[i*DW +: DW]);
    end
    dly_c = DW'(trans_delay(src, dst, cfg_ext));
  end

endmodule

// File: rtl/path_delay_stage.sv
// One module path with per-transition delays and reject/error pulse filtering.
module path_delay_stage
  import path_delay_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter logic [1:0]  RST_VAL = 2'b11
) (
  input logic         clk,
  input logic         rst,
  path_delay_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic [DW-1:0] ONE     = DW'(1);
  localparam logic [DW-1:0] AGE_MAX = '1;

  state_e        state_q, state_d;
  logic [1:0]    in_q;
  logic [1:0]    out_q, out_d;
  logic [1:0]    pend_q, pend_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] age_q, age_d;
  logic          rej_q, rej_d;
  logic          err_q, err_d;

  logic          change_c;
  logic          mature_c;
  logic [DW-1:0] width_c;
  logic [DW-1:0] err_eff_c;
  pulse_cls_e    cls_c;
  logic [1:0]    src_c;
  logic [DW-1:0] dly_c;

  // Change detection, pulse classification and the value a new event starts from.
  always_comb begin
    change_c  = (bus.in_val != in_q);
    mature_c  = (state_q == ST_PEND) && (rem_q == ONE);
    width_c   = (age_q == AGE_MAX) ? age_q : age_q + ONE;
    err_eff_c = (bus.err_lim < bus.rej_lim) ? bus.rej_lim : bus.err_lim;
    cls_c     = CLS_NONE;
    if ((state_q == ST_PEND) && !mature_c && change_c) begin
      if (width_c < bus.rej_lim) begin
        cls_c = CLS_REJ;
      end else if (width_c < err_eff_c) begin
        cls_c = CLS_ERR;
      end else begin
        cls_c = CLS_PASS;
      end
    end
    src_c = out_q;
    if (mature_c || (cls_c == CLS_PASS)) begin
      src_c = pend_q;
    end else if (cls_c == CLS_ERR) begin
      src_c = VX;
    end
  end

  path_delay_sel #(
    .DW (DW)
  ) u_sel (
    .src   (src_c),
    .dst   (bus.in_val),
    .cfg   (bus.dly_cfg),
    .dly_c (dly_c)
  );

  // Next state: retire or age the pending slot, then schedule any new event.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pend_d  = pend_q;
    rem_d   = rem_q;
    age_d   = age_q;
    rej_d   = 1'b0;
    err_d   = 1'b0;

    out_d = src_c;
    rej_d = (cls_c == CLS_REJ);
    err_d = (cls_c == CLS_ERR);

    if (state_q == ST_PEND) begin
      if (mature_c || (cls_c != CLS_NONE)) begin
        state_d = ST_IDLE;
      end else begin
        rem_d = rem_q - ONE;
        age_d = width_c;
      end
    end

    if (change_c && (bus.in_val != src_c)) begin
      state_d = ST_PEND;
      pend_d  = bus.in_val;
      rem_d   = (dly_c == '0) ? ONE : dly_c;
      age_d   = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in_q    <= RST_VAL;
      out_q   <= RST_VAL;
      pend_q  <= RST_VAL;
      rem_q   <= '0;
      age_q   <= '0;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= bus.in_val;
      out_q   <= out_d;
      pend_q  <= pend_d;
      rem_q   <= rem_d;
      age_q   <= age_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_val   = out_q;
  assign bus.busy      = (state_q == ST_PEND);
  assign bus.pulse_rej = rej_q;
  assign bus.pulse_err = err_q;

endmodule

// File: tb/tb_path_delay_stage.sv
// Randomized and directed checks of path_delay_stage against an event-time model.
module tb_path_delay_stage;

  localparam int unsigned DW = 8;
  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  logic clk;
  logic rst;

  path_delay_if #(.DW(DW)) bus ();

  path_delay_stage #(
    .DW      (DW),
    .RST_VAL (2'b11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  // Model: absolute due/start times of a single pending event.
  logic [1:0] m_out;
  logic [1:0] m_inq;
  logic [1:0] m_pval;
  bit         m_pend;
  bit         m_rej;
  bit         m_err;
  int         m_due;
  int         m_start;
  int         m_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic int ref_delay(input logic [1:0] s, input logic [1:0] d,
                                   input logic [6*DW-1:0] cfg);
    int t[6];
    int lo;
    int hi;
    for (int i = 0; i < 6; i++) t[i] = int'(cfg[i*DW +: DW]);
    lo = t[0];
    hi = t[0];
    for (int i = 1; i < 6; i++) begin
      if (t[i] < lo) lo = t[i];
      if (t[i] > hi) hi = t[i];
    end
    if (d == VX) return lo;
    if (s == VX) return hi;
    if (s == V0 && d == V1) return t[0];
    if (s == V1 && d == V0) return t[1];
    if (s == V0 && d == VZ) return t[2];
    if (s == VZ && d == V1) return t[3];
    if (s == V1 && d == VZ) return t[4];
    if (s == VZ && d == V0) return t[5];
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] v);
    int w;
    int rl;
    int el;
    int lat;
    m_rej = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_out  = VX;
      m_inq  = VX;
      m_pend = 1'b0;
    end else begin
      if (m_pend && m_cyc == m_due) begin
        m_out  = m_pval;
        m_pend = 1'b0;
      end
      if (v != m_inq) begin
        if (m_pend) begin
          w  = m_cyc - m_start;
          if (w > 255) w = 255;
          rl = int'(bus.rej_lim);
          el = int'(bus.err_lim);
          if (el < rl) el = rl;
          if (w < rl) m_rej = 1'b1;
          else if (w < el) begin
            m_err = 1'b1;
            m_out = VX;
          end else m_out = m_pval;
          m_pend = 1'b0;
        end
        if (v != m_out) begin
          lat = ref_delay(m_out, v, bus.dly_cfg);
          if (lat < 1) lat = 1;
          m_pend  = 1'b1;
          m_pval  = v;
          m_due   = m_cyc + lat;
          m_start = m_cyc;
        end
      end
      m_inq = v;
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    chk("out_val",   32'(bus.out_val),   32'(m_out));
    chk("busy",      32'(bus.busy),      32'(m_pend));
    chk("pulse_rej", 32'(bus.pulse_rej), 32'(m_rej));
    chk("pulse_err", 32'(bus.pulse_err), 32'(m_err));
  endtask

  // One clock edge: drive at the negedge, predict, compare at the next negedge.
  task automatic step(input logic r, input logic [1:0] v);
    rst        = r;
    bus.in_val = v;
    model_edge(r, v);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_cfg(input int a, input int b, input int c, input int d,
                         input int e, input int f, input int rl, input int el);
    bus.dly_cfg = {DW'(f), DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
    bus.rej_lim = DW'(rl);
    bus.err_lim = DW'(el);
  endtask

  task automatic steps(input int n, input logic [1:0] v);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  logic [1:0] rv;
  logic       rr;

  initial begin
    rst        = 1'b1;
    bus.in_val = V0;
    set_cfg(3, 5, 2, 4, 6, 7, 2, 4);

    step(1'b1, V0);
    step(1'b1, V0);
    chk("rst_out",  32'(bus.out_val), 32'(VX));
    chk("rst_busy", 32'(bus.busy),    32'd0);

    // x->0 after reset release takes the maximum delay (7)
    for (int i = 0; i < 7; i++) begin
      step(1'b0, V0);
      chk("rel_busy", 32'(bus.busy),    32'd1);
      chk("rel_out",  32'(bus.out_val), 32'(VX));
    end
    step(1'b0, V0);
    chk("rel_out7",  32'(bus.out_val), 32'(V0));
    chk("rel_busy7", 32'(bus.busy),    32'd0);

    // 0->1 with t01 = 3
    step(1'b0, V1);
    steps(2, V1);
    chk("rise_early", 32'(bus.out_val), 32'(V0));
    step(1'b0, V1);
    chk("rise_out", 32'(bus.out_val), 32'(V1));

    // settle at 0, then a one-cycle pulse is rejected
    steps(6, V0);
    step(1'b0, V1);
    step(1'b0, V0);
    chk("rej_strobe", 32'(bus.pulse_rej), 32'd1);
    chk("rej_out",    32'(bus.out_val),   32'(V0));
    chk("rej_busy",   32'(bus.busy),      32'd0);
    step(1'b0, V0);
    chk("rej_once", 32'(bus.pulse_rej), 32'd0);

    // settle at 1, then a width-3 pulse becomes x
    steps(4, V1);
    steps(3, V0);
    step(1'b0, V1);
    chk("err_strobe", 32'(bus.pulse_err), 32'd1);
    chk("err_out",    32'(bus.out_val),   32'(VX));
    steps(6, V1);
    chk("err_hold", 32'(bus.out_val), 32'(VX));
    step(1'b0, V1);
    chk("err_recover", 32'(bus.out_val), 32'(V1));

    // width-4 pulse passes: commit 0 at the change, 1 three edges later
    steps(4, V0);
    step(1'b0, V1);
    chk("pass_out0", 32'(bus.out_val), 32'(V0));
    chk("pass_nostb", 32'({bus.pulse_rej, bus.pulse_err}), 32'd0);
    steps(2, V1);
    chk("pass_hold", 32'(bus.out_val), 32'(V0));
    step(1'b0, V1);
    chk("pass_out1", 32'(bus.out_val), 32'(V1));

    // reset while 0->z is pending, then x->z from the release edge
    steps(6, V0);
    step(1'b0, VZ);
    step(1'b1, VZ);
    chk("mrst_out",  32'(bus.out_val), 32'(VX));
    chk("mrst_busy", 32'(bus.busy),    32'd0);
    chk("mrst_stb",  32'({bus.pulse_rej, bus.pulse_err}), 32'd0);
    step(1'b0, VZ);
    steps(6, VZ);
    chk("mrst_hold", 32'(bus.out_val), 32'(VX));
    step(1'b0, VZ);
    chk("mrst_z", 32'(bus.out_val), 32'(VZ));

    // randomized traffic, including zero delays and R > E
    rv = V0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        set_cfg(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      end
      if ($urandom_range(0, 3) == 0) rv = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
